smpl_iter: RTL and testbench

Sample iterator and stream source for the sample-test pipeline. It accepts one triangle plus its bounding box from the bbox stage (R13). It then walks the box on the sub-sample grid in raster order and emits SAMPLES sample positions per cycle, with per-lane valid, alongside the held triangle and color (R14). Its output is the producer end of the stream that the sample test and its scoreboard consume.

---
 rtl/smpl_iter.sv | 149 ++++++++++++++
 tb/tb_smpl_iter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smpl_iter.sv
// Sample iterator: latches a triangle + bbox, walks the box on the sub-sample grid in raster order, SAMPLES lanes per cycle.
// Latency: first batch one cycle after accept; halt_R14H freezes the visible batch, halt_R13H is high while a box is walked.
module smpl_iter #(
   parameter int SIGFIG  = 24,
   parameter int RADIX   = 10,
   parameter int VERTS   = 3,
   parameter int AXIS    = 3,
   parameter int COLORS  = 3,
   parameter int SAMPLES = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
   input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
   input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
   input  logic                                   validTri_R13H,
   input  logic [3:0]                             subSample_RnnnnU,
   input  logic                                   halt_R14H,
   output logic                                   halt_R13H,
   output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
   output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
   output logic [SAMPLES-1:0][1:0][SIGFIG-1:0]    sample_R14S,
   output logic [SAMPLES-1:0]                     validSamp_R14H
);
   localparam int W = SIGFIG + 1;
   localparam logic signed [W-1:0] C_SAMP = W'(SAMPLES);

   typedef enum logic {ST_WAIT, ST_TEST} state_t;

   state_t                                 r_state;
   logic [SIGFIG-1:0]                      r_cur_x, r_cur_y, r_step;
   logic [SIGFIG-1:0]                      r_llx, r_urx, r_ury;
   logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
   logic [COLORS-1:0][SIGFIG-1:0]          r_color;
   logic [SAMPLES-1:0][1:0][SIGFIG-1:0]    r_sample;
   logic [SAMPLES-1:0]                     r_vld;

   logic [SIGFIG-1:0]   w_in_step, w_stp;
   logic signed [W-1:0] w_nx, w_ny, w_base_x, w_base_y, w_urx;
   logic signed [W-1:0] w_lane_x [SAMPLES];
   logic [SAMPLES-1:0]  w_lane_v;
   logic                w_row_ok, w_col_ok, w_in_ok;

   // One extra bit keeps grid arithmetic near the max code from wrapping.
   function automatic logic signed [W-1:0] sx(input logic [SIGFIG-1:0] v);
      return {v[SIGFIG-1], v};
   endfunction

   always_comb begin
      case (subSample_RnnnnU)
         4'b0100: w_in_step = SIGFIG'(1) << (RADIX - 1);
         4'b0010: w_in_step = SIGFIG'(1) << (RADIX - 2);
         4'b0001: w_in_step = SIGFIG'(1) << (RADIX - 3);
         default: w_in_step = SIGFIG'(1) << RADIX;
      endcase
   end

   // Base of the batch to load next: the box origin on accept, otherwise the next raster position.
   always_comb begin
      w_nx     = sx(r_cur_x) + C_SAMP * sx(r_step);
      w_ny     = sx(r_cur_y) + sx(r_step);
      w_row_ok = w_nx <= sx(r_urx);
      w_col_ok = w_ny <= sx(r_ury);
      w_in_ok  = (sx(box_R13S[0][0]) <= sx(box_R13S[1][0])) &&
                 (sx(box_R13S[0][1]) <= sx(box_R13S[1][1]));
      if (r_state == ST_WAIT) begin
         w_base_x = sx(box_R13S[0][0]);
         w_base_y = sx(box_R13S[0][1]);
         w_stp    = w_in_step;
         w_urx    = sx(box_R13S[1][0]);
      end else if (w_row_ok) begin
         w_base_x = w_nx;
         w_base_y = sx(r_cur_y);
         w_stp    = r_step;
         w_urx    = sx(r_urx);
      end else begin
         w_base_x = sx(r_llx);
         w_base_y = w_ny;
         w_stp    = r_step;
         w_urx    = sx(r_urx);
      end
      for (int i = 0; i < SAMPLES; i++) begin
         w_lane_x[i] = w_base_x + $signed(W'(i)) * sx(w_stp);
         w_lane_v[i] = w_lane_x[i] <= w_urx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_WAIT;
         r_cur_x  <= '0;
         r_cur_y  <= '0;
         r_step   <= SIGFIG'(1) << RADIX;
         r_llx    <= '0;
         r_urx    <= '0;
         r_ury    <= '0;
         r_tri    <= '0;
         r_color  <= '0;
         r_sample <= '0;
         r_vld    <= '0;
      end else begin
         case (r_state)
            ST_WAIT: begin
               if (validTri_R13H) begin
                  r_llx  <= box_R13S[0][0];
                  r_urx  <= box_R13S[1][0];
                  r_ury  <= box_R13S[1][1];
                  r_step <= w_in_step;
                  if (w_in_ok) begin
                     r_tri   <= tri_R13S;
                     r_color <= color_R13U;
                     r_cur_x <= w_base_x[SIGFIG-1:0];
                     r_cur_y <= w_base_y[SIGFIG-1:0];
                     for (int i = 0; i < SAMPLES; i++) begin
                        r_sample[i][0] <= w_lane_x[i][SIGFIG-1:0];
                        r_sample[i][1] <= w_base_y[SIGFIG-1:0];
                     end
                     r_vld   <= w_lane_v;
                     r_state <= ST_TEST;
                  end
               end
            end
            ST_TEST: begin
               if (!halt_R14H) begin
                  if (w_row_ok || w_col_ok) begin
                     r_cur_x <= w_base_x[SIGFIG-1:0];
                     r_cur_y <= w_base_y[SIGFIG-1:0];
                     for (int i = 0; i < SAMPLES; i++) begin
                        r_sample[i][0] <= w_lane_x[i][SIGFIG-1:0];
                        r_sample[i][1] <= w_base_y[SIGFIG-1:0];
                     end
                     r_vld <= w_lane_v;
                  end else begin
                     r_vld   <= '0;
                     r_state <= ST_WAIT;
                  end
               end
            end
            default: r_state <= ST_WAIT;
         endcase
      end
   end

   assign halt_R13H      = (r_state == ST_TEST);
   assign tri_R14S       = r_tri;
   assign color_R14U     = r_color;
   assign sample_R14S    = r_sample;
   assign validSamp_R14H = r_vld;
endmodule

// File: tb/tb_smpl_iter.sv
// Bench for smpl_iter: raster walks predicted by nested loops over the box, compared cycle by cycle.
module tb_smpl_iter;
   localparam int S  = 24;
   localparam int NS = 2;

   logic clk = 1'b0;
   logic rst;
   logic [2:0][2:0][S-1:0]  tri_i, tri_o, t_tri, exp_tri;
   logic [2:0][S-1:0]       color_i, color_o, t_color, exp_color;
   logic [1:0][1:0][S-1:0]  box_i;
   logic                    valid_i, halt_in, halt_up;
   logic [3:0]              sub_i;
   logic [NS-1:0][1:0][S-1:0] samp_o, exp_samp;
   logic [NS-1:0]           vld_o;

   int checks = 0;
   int errors = 0;

   typedef struct { longint x; longint y; } bat_t;

   smpl_iter dut (
      .clk(clk), .rst(rst),
      .tri_R13S(tri_i), .color_R13U(color_i), .box_R13S(box_i),
      .validTri_R13H(valid_i), .subSample_RnnnnU(sub_i), .halt_R14H(halt_in),
      .halt_R13H(halt_up), .tri_R14S(tri_o), .color_R14U(color_o),
      .sample_R14S(samp_o), .validSamp_R14H(vld_o)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic longint step_of(input logic [3:0] s);
      case (s)
         4'b1000: return 1024;
         4'b0100: return 512;
         4'b0010: return 256;
         4'b0001: return 128;
         default: return 1024;
      endcase
   endfunction

   task automatic new_tri;
      for (int v = 0; v < 3; v++) begin
         for (int a = 0; a < 3; a++) t_tri[v][a] = S'($urandom);
         t_color[v] = S'($urandom);
      end
   endtask

   task automatic drive_box(input int llx, input int lly, input int urx, input int ury,
                            input logic [3:0] sub);
      box_i[0][0] = S'(llx);
      box_i[0][1] = S'(lly);
      box_i[1][0] = S'(urx);
      box_i[1][1] = S'(ury);
      sub_i       = sub;
   endtask

   // Accept one triangle and follow its whole stream; with hold, the next triangle is presented during TEST.
   task automatic run_tri(input int llx, input int lly, input int urx, input int ury,
                          input logic [3:0] sub, input logic [31:0] mask, input bit hold,
                          input int nllx, input int nlly, input int nurx, input int nury,
                          input logic [3:0] nsub);
      bat_t q[$];
      longint st, lx;
      logic [NS-1:0] ev;
      bit hh;
      int k;
      st = step_of(sub);
      for (longint y = lly; y <= ury; y += st)
         for (longint x = llx; x <= urx; x += NS * st) q.push_back('{x, y});
      if (q.size() > 0) begin
         exp_tri   = t_tri;
         exp_color = t_color;
      end
      checks++;
      if (halt_up !== 1'b0) begin
         errors++;
         $display("FAIL accept_wait halt_R13H got %b exp 0", halt_up);
      end
      drive_box(llx, lly, urx, ury, sub);
      tri_i   = t_tri;
      color_i = t_color;
      valid_i = 1'b1;
      tick;
      if (hold) begin
         new_tri;
         tri_i   = t_tri;
         color_i = t_color;
         drive_box(nllx, nlly, nurx, nury, nsub);
      end else begin
         valid_i = 1'b0;
      end
      k = 0;
      while (q.size() > 0) begin
         if (k > 4000) begin
            errors++;
            $display("FAIL stream_timeout remaining %0d batches exp 0", q.size());
            break;
         end
         for (int i = 0; i < NS; i++) begin
            lx = q[0].x + i * st;
            exp_samp[i][0] = lx[S-1:0];
            exp_samp[i][1] = q[0].y[S-1:0];
            ev[i] = (lx <= urx);
         end
         checks++;
         if (halt_up !== 1'b1) begin
            errors++;
            $display("FAIL test_halt cyc %0d got %b exp 1", k, halt_up);
         end
         checks++;
         if (vld_o !== ev) begin
            errors++;
            $display("FAIL lane_valid cyc %0d got %b exp %b", k, vld_o, ev);
         end
         checks++;
         if (samp_o !== exp_samp) begin
            errors++;
            $display("FAIL sample cyc %0d got %h exp %h", k, samp_o, exp_samp);
         end
         checks++;
         if (tri_o !== exp_tri || color_o !== exp_color) begin
            errors++;
            $display("FAIL tri_color cyc %0d got %h/%h exp %h/%h", k, tri_o, color_o, exp_tri, exp_color);
         end
         hh = (k < 32) ? mask[k] : 1'b0;
         halt_in = hh;
         tick;
         if (!hh) void'(q.pop_front());
         k++;
      end
      halt_in = 1'b0;
      checks++;
      if (halt_up !== 1'b0 || vld_o !== '0) begin
         errors++;
         $display("FAIL end_wait halt %b valid %b exp 0 00", halt_up, vld_o);
      end
      checks++;
      if (samp_o !== exp_samp || tri_o !== exp_tri) begin
         errors++;
         $display("FAIL wait_hold sample %h exp %h", samp_o, exp_samp);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      valid_i = 1'b0;
      halt_in = 1'b0;
      tri_i = '0;
      color_i = '0;
      drive_box(0, 0, 0, 0, 4'b1000);
      exp_tri = '0;
      exp_color = '0;
      exp_samp = '0;
      #12;
      checks++;
      if (halt_up !== 1'b0 || vld_o !== '0) begin
         errors++;
         $display("FAIL reset_ctrl halt %b valid %b exp 0 00", halt_up, vld_o);
      end
      checks++;
      if (tri_o !== '0 || color_o !== '0 || samp_o !== '0) begin
         errors++;
         $display("FAIL reset_data tri %h color %h samp %h exp 0", tri_o, color_o, samp_o);
      end
      rst = 1'b1;
      tick;
   endtask

   task automatic test_1spp;
      new_tri;
      run_tri(0, 0, 2048, 1024, 4'b1000, 32'h0, 1'b0, 0, 0, 0, 0, 4'b0);
   endtask

   task automatic test_stall;
      new_tri;
      run_tri(0, 0, 2048, 1024, 4'b1000, 32'b110, 1'b0, 0, 0, 0, 0, 4'b0);
   endtask

   task automatic test_64spp;
      new_tri;
      run_tri(0, 0, 256, 0, 4'b0001, 32'h0, 1'b0, 0, 0, 0, 0, 4'b0);
   endtask

   task automatic test_empty;
      new_tri;
      run_tri(2048, 0, 1024, 1024, 4'b1000, 32'h0, 1'b1, 0, 0, 1024, 0, 4'b0010);
      run_tri(0, 0, 1024, 0, 4'b0010, 32'h0, 1'b0, 0, 0, 0, 0, 4'b0);
   endtask

   task automatic test_back_to_back;
      new_tri;
      run_tri(0, 0, 2048, 1024, 4'b1000, 32'h0, 1'b1, -512, 0, 1024, 1024, 4'b0100);
      run_tri(-512, 0, 1024, 1024, 4'b0100, 32'h0, 1'b0, 0, 0, 0, 0, 4'b0);
   endtask

   task automatic test_max_edge;
      new_tri;
      run_tri(8388000, -5, 8388607, -5, 4'b1000, 32'h0, 1'b0, 0, 0, 0, 0, 4'b0);
      new_tri;
      run_tri(-8388608, 8387000, -8386000, 8388607, 4'b0110, 32'h5, 1'b0, 0, 0, 0, 0, 4'b0);
   endtask

   task automatic test_reset_mid;
      new_tri;
      drive_box(0, 0, 4096, 4096, 4'b1000);
      tri_i = t_tri;
      color_i = t_color;
      valid_i = 1'b1;
      tick;
      valid_i = 1'b0;
      tick;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (vld_o !== '0 || halt_up !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset valid %b halt %b exp 00 0", vld_o, halt_up);
      end
      checks++;
      if (tri_o !== '0 || samp_o !== '0) begin
         errors++;
         $display("FAIL mid_reset_data tri %h samp %h exp 0", tri_o, samp_o);
      end
      #3;
      rst = 1'b1;
      exp_tri = '0;
      exp_color = '0;
      exp_samp = '0;
      tick;
      new_tri;
      run_tri(100, -300, 1500, 200, 4'b0100, 32'h0, 1'b0, 0, 0, 0, 0, 4'b0);
   endtask

   task automatic test_random;
      int llx, lly, w, h;
      logic [3:0] sub;
      for (int n = 0; n < 24; n++) begin
         llx = int'($urandom_range(6000)) - 3000;
         lly = int'($urandom_range(6000)) - 3000;
         w   = int'($urandom_range(3000)) - 400;
         h   = int'($urandom_range(1500)) - 200;
         case ($urandom_range(5))
            0: sub = 4'b1000;
            1: sub = 4'b0100;
            2: sub = 4'b0010;
            3: sub = 4'b0001;
            4: sub = 4'b0000;
            default: sub = 4'b0110;
         endcase
         new_tri;
         run_tri(llx, lly, llx + w, lly + h, sub, $urandom, 1'b0, 0, 0, 0, 0, 4'b0);
      end
   endtask

   initial begin
      test_reset;
      test_1spp;
      test_stall;
      test_64spp;
      test_empty;
      test_back_to_back;
      test_max_edge;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
